// File: rtl/jtag_pkg.sv
// TAP state encoding, DR-select opcodes and shared constants for the oversampled JTAG TAP.
package jtag_pkg;

  typedef enum logic [3:0] {
    EXIT2_DR = 4'h0,
    EXIT1_DR = 4'h1,
    SHIFT_DR = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EXIT2_IR = 4'h8,
    EXIT1_IR = 4'h9,
    SHIFT_IR = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  localparam int OP_IDCODE   = 7;
  localparam int OP_USERCODE = 8;
  localparam int OP_BYPASS   = -1;  // all-ones at any IR width

endpackage

// File: rtl/jtag_edge_sync.sv
// Synchronises an async level into clk and emits one-clk rise/fall strobes, STAGES clk after the input
// edge (+2 clk when JTAG_TCK_FILTER_EN requires two equal samples first); no backpressure.
module jtag_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              lvl;
  logic              lvl_q;

  // Deliberately unreset: a level held through reset must not look like a fresh edge afterwards.
  always_ff @(posedge clk) begin
    sync <= {sync[STAGES-2:0], din};
  end

`ifdef JTAG_TCK_FILTER_EN
  logic samp_q;
  logic filt;

  always_ff @(posedge clk) begin
    samp_q <= sync[STAGES-1];
    if (sync[STAGES-1] == samp_q) filt <= samp_q;
  end

  assign lvl = filt;
`else
  assign lvl = sync[STAGES-1];
`endif

  always_ff @(posedge clk) begin
    lvl_q <= lvl;
  end

  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

endmodule

// File: rtl/jtag_tap_sync.sv
// IEEE 1149.1 TAP run entirely on clk from oversampled TCK/TMS/TDI, with IDCODE/USERCODE/bypass and NUM_UDR user DRs.
// State/TDO lag raw TCK edges by SYNC_STAGES+1 clk (+2 under JTAG_TCK_FILTER_EN); no backpressure.
module jtag_tap_sync
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH     = 4,
  parameter int          DR_WIDTH     = 8,
  parameter int          NUM_UDR      = 3,
  parameter int          UDR_BASE     = 4,
  parameter logic [31:0] IDCODE_VAL   = 32'h1000_0A01,
  parameter logic [31:0] USERCODE_VAL = 32'h0000_0000,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic                         clk,
  input  logic                         TRST,
  input  logic                         TCK,
  input  logic                         TMS,
  input  logic                         TDI,
  output logic                         TDO,
  output logic                         TDO_EN,
  output logic [IR_WIDTH-1:0]          ir_q,
  output logic [3:0]                   tap_state,
  input  logic [NUM_UDR*DR_WIDTH-1:0]  udr_capture_data,
  output logic [NUM_UDR*DR_WIDTH-1:0]  udr_data,
  output logic [NUM_UDR-1:0]           udr_update,
  output logic                         run_idle
);

  localparam int DR_MAX = (DR_WIDTH > 32) ? DR_WIDTH : 32;
  localparam logic [IR_WIDTH-1:0] IR_IDCODE   = IR_WIDTH'(OP_IDCODE);
  localparam logic [IR_WIDTH-1:0] IR_USERCODE = IR_WIDTH'(OP_USERCODE);
  localparam logic [IR_WIDTH-1:0] IR_BYPASS   = IR_WIDTH'(OP_BYPASS);

  // TMS/TDI get the filter's extra delay too, so they stay aligned with the TCK strobes.
`ifdef JTAG_TCK_FILTER_EN
  localparam int DS = SYNC_STAGES + 2;
`else
  localparam int DS = SYNC_STAGES;
`endif

  logic              tck_rise, tck_fall;
  logic [DS-1:0]     tms_sync, tdi_sync;
  logic              tms_s, tdi_s;
  tap_state_t        state, state_nxt;
  logic [IR_WIDTH-1:0] ir_shift;
  logic [DR_MAX-1:0] dr_shift, dr_cap, dr_nxt, dr_top;
  logic              sel_id, sel_user;
  logic [NUM_UDR-1:0] udr_hit;
  int                dr_len;

  jtag_edge_sync #(.STAGES(SYNC_STAGES)) u_tck_sync (
    .clk  (clk),
    .din  (TCK),
    .rise (tck_rise),
    .fall (tck_fall)
  );

  always_ff @(posedge clk) begin
    tms_sync <= {tms_sync[DS-2:0], TMS};
    tdi_sync <= {tdi_sync[DS-2:0], TDI};
  end

  assign tms_s = tms_sync[DS-1];
  assign tdi_s = tdi_sync[DS-1];

  always_ff @(posedge clk) begin
    if (TRST)          state <= TLR;
    else if (tck_rise) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TLR:      state_nxt = tms_s ? TLR      : RTI;
      RTI:      state_nxt = tms_s ? SEL_DR   : RTI;
      SEL_DR:   state_nxt = tms_s ? SEL_IR   : CAP_DR;
      CAP_DR:   state_nxt = tms_s ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: state_nxt = tms_s ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: state_nxt = tms_s ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: state_nxt = tms_s ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: state_nxt = tms_s ? UPD_DR   : SHIFT_DR;
      UPD_DR:   state_nxt = tms_s ? SEL_DR   : RTI;
      SEL_IR:   state_nxt = tms_s ? TLR      : CAP_IR;
      CAP_IR:   state_nxt = tms_s ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: state_nxt = tms_s ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: state_nxt = tms_s ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: state_nxt = tms_s ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: state_nxt = tms_s ? UPD_IR   : SHIFT_IR;
      UPD_IR:   state_nxt = tms_s ? SEL_DR   : RTI;
      default:  state_nxt = TLR;
    endcase
  end

  // All-ones always means bypass, even if it falls inside the UDR opcode range.
  always_comb begin
    sel_id   = 1'b0;
    sel_user = 1'b0;
    udr_hit  = '0;
    if (ir_q != IR_BYPASS) begin
      if (ir_q == IR_IDCODE)        sel_id   = 1'b1;
      else if (ir_q == IR_USERCODE) sel_user = 1'b1;
      else
        for (int k = 0; k < NUM_UDR; k++)
          udr_hit[k] = (ir_q == IR_WIDTH'(UDR_BASE + k));
    end
  end

  // Shift in at the MSB of the selected length; bits above it stay zero.
  always_comb begin
    dr_cap = '0;
    dr_len = 1;
    if (sel_id) begin
      dr_cap = DR_MAX'(IDCODE_VAL);
      dr_len = 32;
    end else if (sel_user) begin
      dr_cap = DR_MAX'(USERCODE_VAL);
      dr_len = 32;
    end else if (|udr_hit) begin
      dr_len = DR_WIDTH;
      for (int k = 0; k < NUM_UDR; k++)
        if (udr_hit[k]) dr_cap = DR_MAX'(udr_capture_data[k*DR_WIDTH +: DR_WIDTH]);
    end
    dr_top = DR_MAX'(1) << (dr_len - 1);
    dr_nxt = ((dr_shift >> 1) & ~dr_top) | ({DR_MAX{tdi_s}} & dr_top);
  end

  always_ff @(posedge clk) begin
    if (TRST) begin
      ir_q       <= IR_IDCODE;
      ir_shift   <= '0;
      dr_shift   <= '0;
      TDO        <= 1'b0;
      TDO_EN     <= 1'b0;
      udr_data   <= '0;
      udr_update <= '0;
    end else begin
      udr_update <= '0;
      if (tck_rise) begin
        case (state)
          CAP_IR:   ir_shift <= IR_WIDTH'(1);
          SHIFT_IR: ir_shift <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
          CAP_DR:   dr_shift <= dr_cap;
          SHIFT_DR: dr_shift <= dr_nxt;
          default:  ;
        endcase
        if (state_nxt == UPD_IR) ir_q <= ir_shift;
        if (state_nxt == TLR)    ir_q <= IR_IDCODE;
        if (state_nxt == UPD_DR) begin
          udr_update <= udr_hit;
          for (int k = 0; k < NUM_UDR; k++)
            if (udr_hit[k]) udr_data[k*DR_WIDTH +: DR_WIDTH] <= dr_shift[DR_WIDTH-1:0];
        end
      end
      if (tck_fall) begin
        TDO_EN <= (state == SHIFT_IR) || (state == SHIFT_DR);
        if (state == SHIFT_IR)      TDO <= ir_shift[0];
        else if (state == SHIFT_DR) TDO <= dr_shift[0];
        else                        TDO <= 1'b0;
      end
    end
  end

  assign tap_state = state;
  assign run_idle  = (state == RTI);

endmodule

// File: tb/tb_jtag_tap_sync.sv
// Directed + randomised scans of jtag_tap_sync against a bit-stream model of the scan chains.
module tb_jtag_tap_sync;

  localparam int          HALF = 5;
  localparam logic [31:0] IDC  = 32'h1000_0A01;
  localparam logic [31:0] USC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        TRST, TCK, TMS, TDI;
  logic        TDO, TDO_EN, run_idle;
  logic [3:0]  ir_q, tap_state;
  logic [23:0] udr_capture_data, udr_data;
  logic [2:0]  udr_update;

  logic [7:0]  cap_m [3];
  logic [7:0]  udr_m [3];
  int          ncmp = 0;
  int          nfail = 0;
  int          upd_cnt = 0;
  logic [2:0]  upd_last = 3'b000;

  assign udr_capture_data = {cap_m[2], cap_m[1], cap_m[0]};

  jtag_tap_sync dut (
    .clk              (clk),
    .TRST             (TRST),
    .TCK              (TCK),
    .TMS              (TMS),
    .TDI              (TDI),
    .TDO              (TDO),
    .TDO_EN           (TDO_EN),
    .ir_q             (ir_q),
    .tap_state        (tap_state),
    .udr_capture_data (udr_capture_data),
    .udr_data         (udr_data),
    .udr_update       (udr_update),
    .run_idle         (run_idle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (udr_update !== 3'b000) begin
      upd_cnt++;
      upd_last = udr_update;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: observed no finish, expected finish before 5ms");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    ncmp++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // One full TCK period starting with TCK low; TDO is sampled just before the rise.
  task automatic tck(input logic tms_v, input logic tdi_v, output logic tdo_v);
    TMS = tms_v;
    TDI = tdi_v;
    repeat (HALF) @(negedge clk);
    tdo_v = TDO;
    TCK = 1'b1;
    repeat (HALF) @(negedge clk);
    TCK = 1'b0;
  endtask

  task automatic move(input logic tms_v);
    logic unused_tdo;
    tck(tms_v, 1'b0, unused_tdo);
  endtask

  // Chain seen as a bit stream: captured bits come out first, then the bits fed in.
  function automatic logic [63:0] chain(input logic [63:0] capv, input int len,
                                        input logic [63:0] din, input int n,
                                        output logic [63:0] fin);
    logic [127:0] s;
    logic [63:0]  o;
    s = '0;
    o = '0;
    fin = '0;
    for (int i = 0; i < len; i++) s[i[6:0]] = capv[i[5:0]];
    for (int i = 0; i < n; i++) s[7'(len + i)] = din[i[5:0]];
    for (int i = 0; i < n; i++) o[i[5:0]] = s[i[6:0]];
    for (int j = 0; j < len; j++) fin[j[5:0]] = s[7'(n + j)];
    return o;
  endfunction

  task automatic sel_model(input logic [3:0] op, output logic [63:0] capv, output int len);
    if (op == 4'hF)                  begin capv = 64'd0;           len = 1;  end
    else if (op == 4'd7)             begin capv = 64'(IDC);        len = 32; end
    else if (op == 4'd8)             begin capv = 64'(USC);        len = 32; end
    else if (op >= 4'd4 && op <= 4'd6) begin capv = 64'(cap_m[int'(op) - 4]); len = 8; end
    else                             begin capv = 64'd0;           len = 1;  end
  endtask

  // From RTI: full IR or DR scan of n bits, optionally parking in PAUSE after pause_after bits.
  task automatic scan(input bit is_ir, input int n, input logic [63:0] din,
                      input int pause_after, output logic [63:0] dout);
    logic b;
    dout = '0;
    move(1'b1);
    if (is_ir) move(1'b1);
    move(1'b0);
    move(1'b0);
    for (int i = 0; i < n; i++) begin
      tck((i == n - 1) || (i == pause_after - 1), din[i[5:0]], b);
      dout[i[5:0]] = b;
      if (i == pause_after - 1 && i != n - 1) begin
        repeat (4) move(1'b0);
        move(1'b1);
        move(1'b0);
      end
    end
    move(1'b1);
    move(1'b0);
  endtask

  task automatic ir_load(input logic [3:0] op);
    logic [63:0] o, fin, expo;
    expo = chain(64'd1, 4, 64'(op), 4, fin);
    scan(1'b1, 4, 64'(op), 0, o);
    repeat (2) @(negedge clk);
    chk("ir_tdo", o, expo);
    chk("ir_q", 64'(ir_q), fin);
  endtask

  task automatic dr_check(input logic [3:0] op, input int n, input logic [63:0] din,
                          input int pause_after, input string tag);
    logic [63:0] capv, fin, expo, o;
    int len, base;
    bit is_udr;
    is_udr = (op >= 4'd4 && op <= 4'd6);
    sel_model(op, capv, len);
    expo = chain(capv, len, din, n, fin);
    base = upd_cnt;
    scan(1'b0, n, din, pause_after, o);
    if (is_udr) udr_m[int'(op) - 4] = fin[7:0];
    repeat (2) @(negedge clk);
    chk({tag, "_tdo"}, o, expo);
    chk({tag, "_udr"}, 64'(udr_data), 64'({udr_m[2], udr_m[1], udr_m[0]}));
    chk({tag, "_updn"}, 64'(upd_cnt - base), is_udr ? 64'd1 : 64'd0);
    if (is_udr) chk({tag, "_updv"}, 64'(upd_last), 64'(3'b001 << (int'(op) - 4)));
    chk({tag, "_st"}, 64'(tap_state), 64'hC);
  endtask

  initial begin
    logic [3:0] op;
    int base;
    TRST = 1'b1;
    TCK = 1'b0;
    TMS = 1'b1;
    TDI = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cap_m[k] = 8'($urandom);
      udr_m[k] = 8'h00;
    end

    repeat (10) @(negedge clk);
    TRST = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_state", 64'(tap_state), 64'hF);
    chk("rst_ir", 64'(ir_q), 64'h7);
    chk("rst_tdo", 64'(TDO), 64'h0);
    chk("rst_tdo_en", 64'(TDO_EN), 64'h0);
    chk("rst_udr", 64'(udr_data), 64'h0);
    chk("rst_upd", 64'(udr_update), 64'h0);
    chk("rst_run_idle", 64'(run_idle), 64'h0);

    move(1'b0);
    repeat (4) @(negedge clk);
    chk("rti_state", 64'(tap_state), 64'hC);
    chk("rti_run_idle", 64'(run_idle), 64'h1);

    ir_load(4'h7);
    dr_check(4'h7, 32, 64'd0, 0, "idcode");
    ir_load(4'hF);
    dr_check(4'hF, 4, 64'b1101, 0, "bypass");
    ir_load(4'h5);
    dr_check(4'h5, 8, 64'hB1, 4, "udr1_pause");
    cap_m[1] = 8'h3C;
    dr_check(4'h5, 8, 64'($urandom), 0, "udr1_cap");

    for (int it = 0; it < 12; it++) begin
      logic [63:0] capv;
      int len;
      case ($urandom_range(0, 6))
        0: op = 4'h4;
        1: op = 4'h5;
        2: op = 4'h6;
        3: op = 4'h7;
        4: op = 4'h8;
        5: op = 4'hF;
        default: op = 4'($urandom_range(0, 15));
      endcase
      for (int k = 0; k < 3; k++) cap_m[k] = 8'($urandom);
      ir_load(op);
      sel_model(op, capv, len);
      dr_check(op, len + int'($urandom_range(0, 3)), {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0, "rand");
    end

    ir_load(4'hF);
    move(1'b1);
    move(1'b0);
    move(1'b0);
    move(1'b0);
    repeat (4) @(negedge clk);
    chk("tms_mid_state", 64'(tap_state), 64'h2);
    chk("tms_mid_tdo_en", 64'(TDO_EN), 64'h1);
    base = upd_cnt;
    repeat (5) move(1'b1);
    repeat (4) @(negedge clk);
    chk("tms_rst_state", 64'(tap_state), 64'hF);
    chk("tms_rst_ir", 64'(ir_q), 64'h7);
    chk("tms_rst_updn", 64'(upd_cnt - base), 64'd0);
    chk("tms_rst_udr", 64'(udr_data), 64'({udr_m[2], udr_m[1], udr_m[0]}));
    move(1'b0);

    ir_load(4'h5);
    dr_check(4'h5, 8, 64'h5A, 0, "pre_trst");
    move(1'b1);
    move(1'b0);
    move(1'b0);
    move(1'b0);
    move(1'b0);
    base = upd_cnt;
    TRST = 1'b1;
    repeat (4) @(negedge clk);
    TRST = 1'b0;
    for (int k = 0; k < 3; k++) udr_m[k] = 8'h00;
    repeat (2) @(negedge clk);
    chk("trst_state", 64'(tap_state), 64'hF);
    chk("trst_ir", 64'(ir_q), 64'h7);
    chk("trst_udr", 64'(udr_data), 64'h0);
    chk("trst_updn", 64'(upd_cnt - base), 64'd0);
    chk("trst_tdo_en", 64'(TDO_EN), 64'h0);

    move(1'b0);
    TMS = 1'b0;
    TRST = 1'b1;
    TCK = 1'b1;
    repeat (6) @(negedge clk);
    TRST = 1'b0;
    repeat (4) @(negedge clk);
    chk("edge_in_rst_hi", 64'(tap_state), 64'hF);
    TCK = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("edge_in_rst_lo", 64'(tap_state), 64'hF);
    move(1'b0);
    repeat (4) @(negedge clk);
    chk("post_rst_rti", 64'(tap_state), 64'hC);
    dr_check(4'h7, 32, {$urandom, $urandom}, 0, "idcode_post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_sync.md
Name: jtag_tap_sync

Overview:
Parametrised JTAG TAP controller that oversamples TCK/TMS/TDI in the system clk domain and drives TDO without a second clock domain. Sits between the board JTAG pins and the BIST/debug logic, replacing the fixed 4-bit-IR TAP. It adds a configurable IR width, NUM_UDR user data registers with per-channel capture/update strobes, and a tap_state debug output.

Parameters:
IR_WIDTH, 4, instruction register width (≥2)
DR_WIDTH, 8, width of each user data register
NUM_UDR, 3, number of user data registers/channels (1..8)
UDR_BASE, 4, opcode of UDR channel 0; channel k = UDR_BASE+k
IDCODE_VAL, 32'h1000_0A01, IDCODE capture value (bit0 must be 1)
USERCODE_VAL, 32'h0000_0000, USERCODE capture value
SYNC_STAGES, 2, synchroniser depth for TCK/TMS/TDI (≥2)

Ports:
clk  in  1  system clock, must run ≥6× TCK frequency
TRST  in  1  synchronous active-high reset
TCK  in  1  JTAG clock, asynchronous, sampled
TMS  in  1  JTAG mode select, asynchronous
TDI  in  1  JTAG data in, asynchronous
TDO  out  1  JTAG data out
TDO_EN  out  1  high while in SHIFT_IR/SHIFT_DR
ir_q  out  IR_WIDTH  current instruction
tap_state  out  4  TAP state encoding (package)
udr_capture_data  in  NUM_UDR*DR_WIDTH  values loaded at CAPTURE_DR, channel k at [k*DR_WIDTH +: DR_WIDTH]
udr_data  out  NUM_UDR*DR_WIDTH  held per-channel values after UPDATE_DR
udr_update  out  NUM_UDR  one-clk pulse on the selected channel at UPDATE_DR
run_idle  out  1  high while in RUN_TEST_IDLE

Behaviour:
- Clocking: TCK, TMS, TDI each pass through SYNC_STAGES flops. tck_rise = prev 0 / now 1; tck_fall = prev 1 / now 0. All logic runs on clk and is gated by these one-clk strobes.
- Reset (TRST=1 at a clk edge): tap_state=TEST_LOGIC_RESET, ir_q=IDCODE, TDO=0, TDO_EN=0, udr_data=0, udr_update=0, run_idle=0, shift registers=0.
- FSM: standard 16-state IEEE 1149.1 graph. Advances only on tck_rise using the synchronised TMS. Five consecutive tck_rise with TMS=1 reach TEST_LOGIC_RESET from any state. Entering TEST_LOGIC_RESET forces ir_q=IDCODE.
- IR path:
  - CAPTURE_IR loads ir_shift = {0…0,2'b01}.
  - SHIFT_IR shifts right on tck_rise, TDI into the MSB.
  - UPDATE_IR copies ir_shift to ir_q on the tck_rise that enters UPDATE_IR.
- DR select from ir_q: IDCODE(7) → 32-bit; USERCODE(8) → 32-bit; UDR_BASE..UDR_BASE+NUM_UDR-1 → DR_WIDTH channel; all-ones and every other code → 1-bit bypass.
- DR path:
  - CAPTURE_DR loads IDCODE_VAL / USERCODE_VAL / channel capture slice / 0 (bypass).
  - SHIFT_DR shifts right on tck_rise, TDI into the MSB of the selected length.
  - UPDATE_DR, UDR selected: udr_data slice ← shift value and udr_update[k] pulses exactly one clk. Non-UDR selections produce no update.
- PAUSE_DR/PAUSE_IR and EXIT2 hold the shift register contents.
- TDO: updated on tck_fall only, with the LSB of the active shift register while in SHIFT_IR/SHIFT_DR, else 0. TDO_EN tracks the state on the same tck_fall.
- Latency: state change visible SYNC_STAGES+1 clk after the raw TCK rise. TDO changes SYNC_STAGES+1 clk after the raw TCK fall.
- TCK edge coinciding with TRST: reset wins and the edge is dropped.
- TRST mid-shift: shift is discarded and udr_data is cleared.
- Unsynchronised TCK glitch narrower than 1 clk may be missed; no other guarantee.

Optional Feature:
JTAG_TCK_FILTER_EN:
- Defined: a TCK level change is accepted only after the synchronised value has been stable for 2 consecutive clk cycles. Adds 2 clk latency to all strobes and requires clk ≥10× TCK.
- Undefined: the edge is detected directly from the synchroniser output.

Decomposition:
- Package jtag_pkg: 4-bit TAP state encoding (TLR=F, RTI=C, SEL_DR=7, CAP_DR=6, SHIFT_DR=2, EXIT1_DR=1, PAUSE_DR=3, EXIT2_DR=0, UPD_DR=5, SEL_IR=4, CAP_IR=E, SHIFT_IR=A, EXIT1_IR=9, PAUSE_IR=B, EXIT2_IR=8, UPD_IR=D); opcode constants IDCODE=7, USERCODE=8, BYPASS=all-ones.
- Sub-module jtag_edge_sync: synchroniser, edge detection and optional filter, instantiated once for TCK. TMS/TDI use plain synchronisers aligned to the same depth.

Test Plan:
- TRST pulse, then idle → tap_state=F, ir_q=4'h7, TDO=0, all udr_data=0.
- IR scan of 4'h7, then 32-bit DR scan with TDI=0 → TDO LSB-first equals 32'h1000_0A01.
- IR scan 4'hF, DR scan of pattern 1,0,1,1 → TDO shows the same pattern delayed one TCK (first bit 0).
- IR scan shifting 4'h5 → first four TDO bits read 1,0,0,0 (capture 4'b0001); ir_q=5.
- IR 4'h5 (channel 1), DR scan 8'hB1 through PAUSE_DR ×4 then EXIT2/UPDATE → udr_data[15:8]=8'hB1 and udr_update=3'b010 for exactly 1 clk; channel 1 capture 8'h3C reads back 8'h3C on the next scan.
- Mid SHIFT_DR: 5 TMS=1 TCK edges → state F, ir_q=7, no udr_update. Repeat with TRST asserted mid-shift → same outcome and udr_data cleared.
